rf_scrubber_arbiter: RTL and testbench

- Shares the two register-file read ports between the OP stage and a background scrubber. The scrubber walks the RF in register pairs during idle cycles.
- Each pair is read; correctable errors are rewritten with the corrected value through a spare RF write slot. Uncorrectable errors are reported.
- The OP stage always has absolute priority. The scrubber only uses ports the pipeline leaves free, and aborts the instant the OP stage needs them.

---
 rtl/rf_scrubber_arbiter.sv | 135 +++++++++++++
 tb/tb_rf_scrubber_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_scrubber_arbiter.sv
// Background RF scrubber that borrows the read ports only when the OP stage leaves them idle.
// Correctable errors are rewritten through a spare write slot; uncorrectable ones are reported.
module rf_scrubber_arbiter #(
   parameter int IDLE_WAIT = 4,
   parameter int CNT_W     = 8
) (
   input  logic             s_clk_i,
   input  logic             s_reset_i,
   input  logic             s_en_i,
   input  logic             s_op_req_i,
   input  logic [4:0]       s_op_rs1_i,
   input  logic [4:0]       s_op_rs2_i,
   output logic [4:0]       s_rf_rs1_o,
   output logic [4:0]       s_rf_rs2_o,
   input  logic [31:0]      s_rf_p1_i,
   input  logic [31:0]      s_rf_p2_i,
   input  logic [1:0]       s_rf_ce_i,
   input  logic [1:0]       s_rf_uce_i,
   input  logic             s_wb_busy_i,
   output logic             s_scr_we_o,
   output logic [4:0]       s_scr_wadd_o,
   output logic [31:0]      s_scr_wval_o,
   output logic [1:0]       s_uce_o,
   output logic [3:0]       s_uce_pair_o,
   output logic             s_pass_o,
   output logic [CNT_W-1:0] s_ce_cnt_o,
   output logic [1:0]       s_state_o
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_READ  = 2'd1;
   localparam logic [1:0] ST_CHECK = 2'd2;
   localparam logic [1:0] ST_FIX   = 2'd3;
   localparam logic [3:0] WAIT_LAST = 4'(IDLE_WAIT - 1);

   logic [1:0]  state;
   logic [3:0]  k;
   logic [3:0]  wait_cnt;
   logic [1:0]  pend;
   logic [31:0] dat1;
   logic [31:0] dat2;
   logic        scrub_drive;
   logic [1:0]  ce_ok;
   logic        fix_go1;
   logic        fix_go2;
   logic        fix_done;

   // The OP stage wins the ports outright, even in the scrubber's own READ cycle.
   assign scrub_drive = (state == ST_READ) && !s_op_req_i;
   assign s_rf_rs1_o  = scrub_drive ? {k, 1'b0} : s_op_rs1_i;
   assign s_rf_rs2_o  = scrub_drive ? {k, 1'b1} : s_op_rs2_i;
   assign s_state_o   = state;

   // UCE dominates CE; register 0 is hardwired and never rewritten.
   assign ce_ok    = s_rf_ce_i & ~s_rf_uce_i & {1'b1, (k != 4'd0)};
   assign fix_go1  = !s_wb_busy_i && pend[0];
   assign fix_go2  = !s_wb_busy_i && !pend[0] && pend[1];
   assign fix_done = fix_go2 || (fix_go1 && !pend[1]);

   always_ff @(posedge s_clk_i) begin
      if (s_reset_i) begin
         state        <= ST_IDLE;
         k            <= 4'd0;
         wait_cnt     <= 4'd0;
         pend         <= 2'b00;
         dat1         <= 32'd0;
         dat2         <= 32'd0;
         s_scr_we_o   <= 1'b0;
         s_scr_wadd_o <= 5'd0;
         s_scr_wval_o <= 32'd0;
         s_uce_o      <= 2'b00;
         s_uce_pair_o <= 4'd0;
         s_pass_o     <= 1'b0;
         s_ce_cnt_o   <= '0;
      end else begin
         s_scr_we_o <= 1'b0;
         s_uce_o    <= 2'b00;
         s_pass_o   <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (s_en_i && !s_op_req_i) begin
                  if (wait_cnt == WAIT_LAST) begin
                     wait_cnt <= 4'd0;
                     state    <= ST_READ;
                  end else begin
                     wait_cnt <= wait_cnt + 4'd1;
                  end
               end else begin
                  wait_cnt <= 4'd0;
               end
            end
            ST_READ: begin
               state <= (s_op_req_i || !s_en_i) ? ST_IDLE : ST_CHECK;
            end
            ST_CHECK: begin
               s_uce_o      <= s_rf_uce_i;
               s_uce_pair_o <= k;
               pend         <= ce_ok;
               dat1         <= s_rf_p1_i;
               dat2         <= s_rf_p2_i;
               if (ce_ok == 2'b00) begin
                  k        <= k + 4'd1;
                  s_pass_o <= (k == 4'd15);
                  state    <= ST_IDLE;
               end else begin
                  state <= ST_FIX;
               end
            end
            ST_FIX: begin
               if (fix_go1) begin
                  s_scr_we_o   <= 1'b1;
                  s_scr_wadd_o <= {k, 1'b0};
                  s_scr_wval_o <= dat1;
                  pend[0]      <= 1'b0;
               end else if (fix_go2) begin
                  s_scr_we_o   <= 1'b1;
                  s_scr_wadd_o <= {k, 1'b1};
                  s_scr_wval_o <= dat2;
                  pend[1]      <= 1'b0;
               end
               if ((fix_go1 || fix_go2) && (s_ce_cnt_o != '1)) begin
                  s_ce_cnt_o <= s_ce_cnt_o + 1'b1;
               end
               if (fix_done) begin
                  k        <= k + 4'd1;
                  s_pass_o <= (k == 4'd15);
                  state    <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rf_scrubber_arbiter.sv
// Randomized bench for rf_scrubber_arbiter: pair-level reference model feeding scoreboard queues,
// with a free-running monitor that pops expectations whenever the DUT reports an event.
module tb_rf_scrubber_arbiter;

   localparam int IDLE_WAIT = 4;
   localparam int CNT_W     = 8;

   logic             s_clk_i = 1'b0;
   logic             s_reset_i;
   logic             s_en_i;
   logic             s_op_req_i;
   logic [4:0]       s_op_rs1_i;
   logic [4:0]       s_op_rs2_i;
   logic [4:0]       s_rf_rs1_o;
   logic [4:0]       s_rf_rs2_o;
   logic [31:0]      s_rf_p1_i;
   logic [31:0]      s_rf_p2_i;
   logic [1:0]       s_rf_ce_i;
   logic [1:0]       s_rf_uce_i;
   logic             s_wb_busy_i;
   logic             s_scr_we_o;
   logic [4:0]       s_scr_wadd_o;
   logic [31:0]      s_scr_wval_o;
   logic [1:0]       s_uce_o;
   logic [3:0]       s_uce_pair_o;
   logic             s_pass_o;
   logic [CNT_W-1:0] s_ce_cnt_o;
   logic [1:0]       s_state_o;

   rf_scrubber_arbiter #(.IDLE_WAIT(IDLE_WAIT), .CNT_W(CNT_W)) dut (
      .s_clk_i(s_clk_i), .s_reset_i(s_reset_i), .s_en_i(s_en_i), .s_op_req_i(s_op_req_i),
      .s_op_rs1_i(s_op_rs1_i), .s_op_rs2_i(s_op_rs2_i),
      .s_rf_rs1_o(s_rf_rs1_o), .s_rf_rs2_o(s_rf_rs2_o),
      .s_rf_p1_i(s_rf_p1_i), .s_rf_p2_i(s_rf_p2_i), .s_rf_ce_i(s_rf_ce_i), .s_rf_uce_i(s_rf_uce_i),
      .s_wb_busy_i(s_wb_busy_i), .s_scr_we_o(s_scr_we_o), .s_scr_wadd_o(s_scr_wadd_o),
      .s_scr_wval_o(s_scr_wval_o), .s_uce_o(s_uce_o), .s_uce_pair_o(s_uce_pair_o),
      .s_pass_o(s_pass_o), .s_ce_cnt_o(s_ce_cnt_o), .s_state_o(s_state_o)
   );

   // clock / reset
   always #5 s_clk_i = ~s_clk_i;

   // scoreboard state: write = {count after write, addr, data}; uce = {flags, pair}
   logic [44:0] wr_q[$];
   logic [5:0]  uce_q[$];
   logic [7:0]  pass_q[$];
   int          total = 0;
   int          bad = 0;
   int          k_m = 0;
   int          cnt_m = 0;
   int          pass_n = 0;
   int          pass_seen = 0;
   bit          mon_on = 1'b0;
   logic        prev_busy = 1'b0;
   logic [44:0] e_w;
   logic [5:0]  e_u;
   logic [7:0]  e_p;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   function automatic logic [4:0] rnd5();
      return 5'($urandom_range(0, 31));
   endfunction

   // driver: one clock of inputs, mux check away from the edge
   task automatic drive_cycle(input logic en, input logic op, input logic [4:0] o1,
                              input logic [4:0] o2, input logic busy,
                              input logic [4:0] e1, input logic [4:0] e2, input string nm);
      s_en_i      = en;
      s_op_req_i  = op;
      s_op_rs1_i  = o1;
      s_op_rs2_i  = o2;
      s_wb_busy_i = busy;
      @(negedge s_clk_i);
      chk({nm, "_rs1"}, 64'(s_rf_rs1_o), 64'(e1));
      chk({nm, "_rs2"}, 64'(s_rf_rs2_o), 64'(e2));
      @(posedge s_clk_i);
      #1;
   endtask

   task automatic idle_good();
      logic [4:0] o1, o2;
      o1 = rnd5();
      o2 = rnd5();
      drive_cycle(1'b1, 1'b0, o1, o2, 1'($urandom_range(0, 1)), o1, o2, "idle_mux");
   endtask

   // One scrub attempt of the current pair. rd_mode: 0 proceed, 1 OP preempt, 2 enable dropped.
   task automatic do_pair(input int noise, input int rd_mode, input logic [4:0] p_rs1,
                          input logic [4:0] p_rs2, input logic [1:0] ce, input logic [1:0] uce,
                          input logic [31:0] d1, input logic [31:0] d2,
                          input int busy1, input int busy2, input bit rst_fix);
      logic [4:0]  o1, o2, a1, a2;
      logic [44:0] wl[$];
      int          busy_n[2];
      int          c_new;
      int          g;
      busy_n[0] = busy1;
      busy_n[1] = busy2;
      for (int s = 0; s < noise; s++) begin
         g = $urandom_range(0, IDLE_WAIT - 1);
         for (int c = 0; c < g; c++) idle_good();
         o1 = rnd5();
         o2 = rnd5();
         if ($urandom_range(0, 1) == 1) drive_cycle(1'b1, 1'b1, o1, o2, 1'b0, o1, o2, "noise_mux");
         else drive_cycle(1'b0, 1'b0, o1, o2, 1'b0, o1, o2, "noise_mux");
      end
      for (int c = 0; c < IDLE_WAIT; c++) idle_good();
      a1 = {4'(k_m), 1'b0};
      a2 = {4'(k_m), 1'b1};
      o1 = rnd5();
      o2 = rnd5();
      if (rd_mode == 1) drive_cycle(1'b1, 1'b1, p_rs1, p_rs2, 1'b0, p_rs1, p_rs2, "read_preempt");
      else drive_cycle(rd_mode == 0, 1'b0, o1, o2, 1'b0, a1, a2, "read_addr");
      if (rd_mode != 0) return;

      // reference model: what this pair must produce, independent of timing
      c_new = cnt_m;
      for (int p = 0; p < 2; p++) begin
         if (ce[p] && !uce[p] && (2 * k_m + p) != 0) begin
            if (c_new < 255) c_new++;
            wl.push_back({8'(c_new), 5'(2 * k_m + p), (p == 1) ? d2 : d1});
         end
      end
      if (uce != 2'b00) uce_q.push_back({uce, 4'(k_m)});
      if (!(rst_fix && wl.size() > 0)) begin
         foreach (wl[i]) wr_q.push_back(wl[i]);
         cnt_m = c_new;
         if (k_m == 15) begin
            pass_q.push_back(8'(pass_n));
            pass_n++;
         end
         k_m = (k_m + 1) % 16;
      end

      s_rf_ce_i  = ce;
      s_rf_uce_i = uce;
      s_rf_p1_i  = d1;
      s_rf_p2_i  = d2;
      o1 = rnd5();
      o2 = rnd5();
      drive_cycle(1'b1, 1'($urandom_range(0, 1)), o1, o2, 1'($urandom_range(0, 1)), o1, o2,
                  "check_mux");
      s_rf_ce_i  = 2'b00;
      s_rf_uce_i = 2'b00;
      s_rf_p1_i  = $urandom;
      s_rf_p2_i  = $urandom;

      if (rst_fix && wl.size() > 0) begin
         s_reset_i = 1'b1;
         drive_cycle(1'b1, 1'b0, o1, o2, 1'b0, o1, o2, "fixrst_mux");
         s_reset_i  = 1'b0;
         s_op_req_i = 1'b1;
         k_m   = 0;
         cnt_m = 0;
         @(negedge s_clk_i);
         chk("fixrst_we", 64'(s_scr_we_o), 64'd0);
         chk("fixrst_cnt", 64'(s_ce_cnt_o), 64'd0);
         chk("fixrst_state", 64'(s_state_o), 64'd0);
         @(posedge s_clk_i);
         #1;
         return;
      end
      for (int i = 0; i < wl.size(); i++) begin
         for (int b = 0; b < busy_n[i]; b++) begin
            o1 = rnd5();
            o2 = rnd5();
            drive_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), o1, o2, 1'b1,
                        o1, o2, "fix_mux");
         end
         o1 = rnd5();
         o2 = rnd5();
         drive_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), o1, o2, 1'b0,
                     o1, o2, "fix_mux");
      end
      s_wb_busy_i = 1'b0;
   endtask

   // monitor: pops the expected queue whenever the DUT presents an event
   always @(negedge s_clk_i) begin
      if (mon_on) begin
         if (s_scr_we_o === 1'b1) begin
            chk("wr_while_busy", 64'(prev_busy), 64'd0);
            if (wr_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL wr_unexpected actual=addr %0d data %0h required=no write",
                        s_scr_wadd_o, s_scr_wval_o);
            end else begin
               e_w = wr_q.pop_front();
               chk("wr_cnt_addr_data", 64'({s_ce_cnt_o, s_scr_wadd_o, s_scr_wval_o}), 64'(e_w));
            end
         end
         if (s_uce_o !== 2'b00) begin
            if (uce_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL uce_unexpected actual=%0b pair %0d required=none", s_uce_o, s_uce_pair_o);
            end else begin
               e_u = uce_q.pop_front();
               chk("uce_flags_pair", 64'({s_uce_o, s_uce_pair_o}), 64'(e_u));
            end
         end
         if (s_pass_o === 1'b1) begin
            if (pass_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL pass_unexpected actual=pulse required=none");
            end else begin
               e_p = pass_q.pop_front();
               chk("pass_index", 64'(pass_seen), 64'(e_p));
            end
            pass_seen++;
         end
         prev_busy = s_wb_busy_i;
      end
   end

   initial begin
      int rm;
      logic [1:0] rce, ruce;
      s_reset_i   = 1'b1;
      s_en_i      = 1'b1;
      s_op_req_i  = 1'b0;
      s_op_rs1_i  = 5'd7;
      s_op_rs2_i  = 5'd13;
      s_rf_p1_i   = 32'd0;
      s_rf_p2_i   = 32'd0;
      s_rf_ce_i   = 2'b00;
      s_rf_uce_i  = 2'b00;
      s_wb_busy_i = 1'b0;
      repeat (3) @(posedge s_clk_i);
      #1;
      @(negedge s_clk_i);
      chk("rst_state", 64'(s_state_o), 64'd0);
      chk("rst_cnt", 64'(s_ce_cnt_o), 64'd0);
      chk("rst_we", 64'(s_scr_we_o), 64'd0);
      chk("rst_wadd_wval", 64'({s_scr_wadd_o, s_scr_wval_o}), 64'd0);
      chk("rst_uce", 64'({s_uce_o, s_uce_pair_o}), 64'd0);
      chk("rst_pass", 64'(s_pass_o), 64'd0);
      chk("rst_mux", 64'({s_rf_rs1_o, s_rf_rs2_o}), 64'({5'd7, 5'd13}));
      @(posedge s_clk_i);
      #1;
      s_reset_i = 1'b0;
      mon_on    = 1'b1;

      // clean full pass; first READ lands on the 5th cycle after release
      for (int p = 0; p < 16; p++) do_pair(0, 0, 5'd0, 5'd0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
      do_pair(0, 0, 5'd0, 5'd0, 2'b01, 2'b00, 32'h5555, 0, 0, 0, 0);      // pair 0, r0 ignored
      do_pair(0, 0, 5'd0, 5'd0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
      do_pair(0, 0, 5'd0, 5'd0, 2'b11, 2'b00, 32'h11, 32'h22, 0, 0, 0);   // pair 2
      do_pair(0, 0, 5'd0, 5'd0, 2'b01, 2'b01, 32'h33, 0, 0, 0, 0);        // pair 3, UCE wins
      do_pair(0, 0, 5'd0, 5'd0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
      do_pair(0, 0, 5'd0, 5'd0, 2'b10, 2'b00, 0, 32'hDEADBEEF, 3, 0, 0);  // pair 5, busy x3
      do_pair(0, 0, 5'd0, 5'd0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
      do_pair(0, 1, 5'd3, 5'd9, 2'b00, 2'b00, 0, 0, 0, 0, 0);             // pair 7 preempted
      do_pair(0, 0, 5'd0, 5'd0, 2'b00, 2'b00, 0, 0, 0, 0, 0);             // pair 7 retried

      for (int n = 0; n < 200; n++) begin
         rm = $urandom_range(0, 9);
         rce = 2'($urandom_range(0, 3));
         ruce = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         do_pair($urandom_range(0, 2), (rm == 0) ? 1 : ((rm == 1) ? 2 : 0), rnd5(), rnd5(),
                 rce, ruce, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), 0);
      end

      // reset in the first FIX cycle, then confirm the walk restarts at pair 0
      do_pair(0, 0, 5'd0, 5'd0, 2'b11, 2'b00, 32'hAAAA, 32'hBBBB, 0, 0, 1);
      do_pair(0, 0, 5'd0, 5'd0, 2'b10, 2'b00, 0, 32'h0BAD, 0, 0, 0);

      // saturate the correction counter
      for (int n = 0; n < 140; n++)
         do_pair(0, 0, 5'd0, 5'd0, 2'b11, 2'b00, $urandom, $urandom, 0, $urandom_range(0, 1), 0);

      repeat (4) drive_cycle(1'b1, 1'b1, 5'd1, 5'd2, 1'b0, 5'd1, 5'd2, "tail_mux");
      chk("final_cnt_saturated", 64'(s_ce_cnt_o), 64'd255);
      chk("final_cnt_model", 64'(s_ce_cnt_o), 64'(cnt_m));
      chk("wr_q_drained", 64'(wr_q.size()), 64'd0);
      chk("uce_q_drained", 64'(uce_q.size()), 64'd0);
      chk("pass_q_drained", 64'(pass_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
